// File: rtl/l1i_prefetcher_pkg.sv
// Shared types for the L1I sequential prefetcher: FSM states, line geometry, line-address helpers.
package l1i_pkg;
  localparam int LINE_BYTES = 32;
  localparam int LINE_BITS  = $clog2(LINE_BYTES);
  localparam int PAGE_BITS  = 12;

  typedef logic [31-LINE_BITS:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE
  } pf_state_e;

  function automatic logic [31:0] line_to_addr(input line_t l);
    return {l, {LINE_BITS{1'b0}}};
  endfunction

  function automatic logic [31-PAGE_BITS:0] line_page(input line_t l);
    return l[$bits(line_t)-1 -: 32-PAGE_BITS];
  endfunction
endpackage

// File: rtl/l1i_prefetcher_if.sv
// Miss, L2 and L1I-fill signals of the prefetcher; master is the prefetcher, slave its environment.
interface l1i_prefetcher_if;
  logic         miss_valid;
  logic [31:0]  miss_paddr;
  logic         demand_pending;
  logic [31:0]  l2_addr;
  logic         l2_request;
  logic [255:0] l2_data;
  logic         l2_done;
  logic [31:0]  prefetch_addr;
  logic [255:0] prefetch_data;
  logic         prefetch_valid;

  modport master (
    input  miss_valid, miss_paddr, demand_pending, l2_data, l2_done,
    output l2_addr, l2_request, prefetch_addr, prefetch_data, prefetch_valid
  );

  modport slave (
    output miss_valid, miss_paddr, demand_pending, l2_data, l2_done,
    input  l2_addr, l2_request, prefetch_addr, prefetch_data, prefetch_valid
  );
endinterface

// File: rtl/l1i_prefetcher_pf_queue.sv
// Candidate FIFO of line addresses with an associative lookup port for duplicate filtering.
module pf_queue
  import l1i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  line_t push_line,
  input  logic  pop,
  output line_t head_line,
  output logic  full,
  output logic  empty,
  input  line_t lookup_line,
  output logic  lookup_hit
);
  localparam int PW = $clog2(DEPTH);

  line_t [DEPTH-1:0] entry_q, entry_d;
  logic  [DEPTH-1:0] vld_q, vld_d;
  logic  [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Slots fill contiguously, so the write slot is occupied only when every slot is.
  assign empty     = !vld_q[rd_ptr_q];
  assign full      = vld_q[wr_ptr_q];
  assign head_line = entry_q[rd_ptr_q];

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (entry_q[i] == lookup_line)) lookup_hit = 1'b1;
    end
  end

  // Pop is applied before push so a full queue accepts both in one cycle.
  always_comb begin
    entry_d  = entry_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop && !empty) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push && (!full || (pop && !empty))) begin
      entry_d[wr_ptr_q] = push_line;
      vld_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      entry_q  <= entry_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/l1i_prefetcher.sv
// L1I next-line prefetcher: miss-driven candidate generator, duplicate filter and L2 request FSM.
// Build option L1I_PF_PAGE_CROSS_EN: when defined, candidates may cross a 4KB page boundary.
module l1i_prefetcher
  import l1i_pkg::*;
#(
  parameter int DEGREE = 2,
  parameter int QDEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  l1i_prefetcher_if.master bus
);
  // state  | meaning
  // IDLE   | waiting for a queued candidate while no demand fill is in flight
  // REQ    | l2_request held with stable l2_addr until l2_done
  // WRITE  | prefetch_valid high for one cycle, line written into L1I

`ifdef L1I_PF_PAGE_CROSS_EN
  localparam bit PAGE_CROSS_EN = 1'b1;
`else
  localparam bit PAGE_CROSS_EN = 1'b0;
`endif

  pf_state_e             state_q, state_d;
  line_t                 gen_line_q, gen_line_d;
  logic [31-PAGE_BITS:0] gen_page_q, gen_page_d;
  logic [2:0]            gen_left_q, gen_left_d;
  line_t                 last_line_q, last_line_d;
  logic                  last_vld_q, last_vld_d;
  logic [31:0]           l2_addr_q, l2_addr_d;
  logic                  l2_req_q, l2_req_d;
  logic [31:0]           pf_addr_q, pf_addr_d;
  logic [255:0]          pf_data_q, pf_data_d;
  logic                  pf_valid_q, pf_valid_d;

  logic  q_push, q_pop, q_full, q_empty, q_hit;
  line_t q_head;
  logic  cand_cross, cand_dup;
  logic  unused_low;

  pf_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_line   (gen_line_q),
    .pop         (q_pop),
    .head_line   (q_head),
    .full        (q_full),
    .empty       (q_empty),
    .lookup_line (gen_line_q),
    .lookup_hit  (q_hit)
  );

  assign cand_cross = line_page(gen_line_q) != gen_page_q;
  assign cand_dup   = q_hit || (last_vld_q && (last_line_q == gen_line_q));
  assign unused_low = ^bus.miss_paddr[LINE_BITS-1:0];

  // Generator: gen_left_q counts down the candidates still to offer.
  always_comb begin
    gen_line_d = gen_line_q;
    gen_page_d = gen_page_q;
    gen_left_d = gen_left_q;
    q_push     = 1'b0;
    if (bus.miss_valid) begin
      // A new miss preempts whatever candidate was pending.
      gen_line_d = line_t'(bus.miss_paddr[31:LINE_BITS]) + line_t'(1);
      gen_page_d = bus.miss_paddr[31:PAGE_BITS];
      gen_left_d = 3'(DEGREE);
    end else if (gen_left_q != '0) begin
      if (cand_cross && !PAGE_CROSS_EN) begin
        gen_left_d = '0;
      end else begin
        q_push     = !cand_dup && (!q_full || q_pop);
        gen_line_d = gen_line_q + line_t'(1);
        gen_left_d = gen_left_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    l2_addr_d   = l2_addr_q;
    l2_req_d    = l2_req_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    pf_valid_d  = 1'b0;
    last_line_d = last_line_q;
    last_vld_d  = last_vld_q;
    q_pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty && !bus.demand_pending) begin
          q_pop       = 1'b1;
          l2_addr_d   = line_to_addr(q_head);
          l2_req_d    = 1'b1;
          last_line_d = q_head;
          last_vld_d  = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.l2_done) begin
          l2_req_d   = 1'b0;
          pf_addr_d  = l2_addr_q;
          pf_data_d  = bus.l2_data;
          pf_valid_d = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gen_line_q  <= '0;
      gen_page_q  <= '0;
      gen_left_q  <= '0;
      last_line_q <= '0;
      last_vld_q  <= 1'b0;
      l2_addr_q   <= '0;
      l2_req_q    <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pf_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_line_q  <= gen_line_d;
      gen_page_q  <= gen_page_d;
      gen_left_q  <= gen_left_d;
      last_line_q <= last_line_d;
      last_vld_q  <= last_vld_d;
      l2_addr_q   <= l2_addr_d;
      l2_req_q    <= l2_req_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pf_valid_q  <= pf_valid_d;
    end
  end

  assign bus.l2_addr        = l2_addr_q;
  assign bus.l2_request     = l2_req_q;
  assign bus.prefetch_addr  = pf_addr_q;
  assign bus.prefetch_data  = pf_data_q;
  assign bus.prefetch_valid = pf_valid_q;
endmodule

// File: tb/tb_l1i_prefetcher.sv
// Directed bench for l1i_prefetcher: DEGREE=2/QDEPTH=4 main instance, DEGREE=4/QDEPTH=2 queue-full instance.
module tb_l1i_prefetcher;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  l1i_prefetcher_if bus ();
  l1i_prefetcher_if bus2 ();

  l1i_prefetcher #(.DEGREE(2), .QDEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  l1i_prefetcher #(.DEGREE(4), .QDEPTH(2)) u_dut_q2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hC3A5_5A3C}};
  endfunction

  function automatic logic req_of(input bit s);
    return s ? bus2.l2_request : bus.l2_request;
  endfunction
  function automatic logic [31:0] addr_of(input bit s);
    return s ? bus2.l2_addr : bus.l2_addr;
  endfunction
  function automatic logic pv_of(input bit s);
    return s ? bus2.prefetch_valid : bus.prefetch_valid;
  endfunction
  function automatic logic [31:0] pa_of(input bit s);
    return s ? bus2.prefetch_addr : bus.prefetch_addr;
  endfunction
  function automatic logic [255:0] pd_of(input bit s);
    return s ? bus2.prefetch_data : bus.prefetch_data;
  endfunction

  task automatic drive_done(input bit s, input logic d, input logic [255:0] data);
    if (s) begin bus2.l2_done = d; bus2.l2_data = data; end
    else   begin bus.l2_done  = d; bus.l2_data  = data; end
  endtask

  task automatic miss(input bit s, input logic [31:0] a);
    if (s) begin bus2.miss_valid = 1'b1; bus2.miss_paddr = a; end
    else   begin bus.miss_valid  = 1'b1; bus.miss_paddr  = a; end
    step();
    if (s) bus2.miss_valid = 1'b0;
    else   bus.miss_valid  = 1'b0;
  endtask

  // Waits for a request, checks it is held, completes it and checks the one-cycle L1I write.
  task automatic serve(input bit s, input logic [31:0] a, input string tag);
    int cyc = 0;
    while (!req_of(s) && cyc < 50) begin
      step();
      cyc++;
    end
    check_val({tag, " req"}, req_of(s), 1'b1);
    check_val({tag, " addr"}, addr_of(s), a);
    step();
    step();
    check_val({tag, " hold"}, {req_of(s), addr_of(s)}, {1'b1, a});
    drive_done(s, 1'b1, pat(a));
    step();
    drive_done(s, 1'b0, '0);
    check_val({tag, " pv"}, pv_of(s), 1'b1);
    check_val({tag, " pa"}, pa_of(s), a);
    check_val({tag, " pd"}, pd_of(s), pat(a));
    check_val({tag, " req_clr"}, req_of(s), 1'b0);
    step();
    check_val({tag, " pv_1cyc"}, pv_of(s), 1'b0);
  endtask

  task automatic expect_quiet(input bit s, input int n, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (req_of(s) || pv_of(s)) seen = 1'b1;
    end
    check_val(tag, seen, 1'b0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    bus.miss_valid  = 1'b0; bus.miss_paddr  = '0; bus.demand_pending  = 1'b0;
    bus.l2_data     = '0;   bus.l2_done     = 1'b0;
    bus2.miss_valid = 1'b0; bus2.miss_paddr = '0; bus2.demand_pending = 1'b0;
    bus2.l2_data    = '0;   bus2.l2_done    = 1'b0;
    step();
    step();
    reset = 1'b0;

    check_val("rst l2_request", bus.l2_request, 1'b0);
    check_val("rst l2_addr", bus.l2_addr, 32'h0);
    check_val("rst pv", bus.prefetch_valid, 1'b0);
    check_val("rst pa", bus.prefetch_addr, 32'h0);
    check_val("rst pd", bus.prefetch_data, 256'h0);

    // Single miss with latency and back-to-back issue.
    miss(0, 32'h0000_1040);
    check_val("lat t", bus.l2_request, 1'b0);
    step();
    check_val("lat t+1", bus.l2_request, 1'b0);
    step();
    check_val("lat t+2", {bus.l2_request, bus.l2_addr}, {1'b1, 32'h0000_1060});
    serve(0, 32'h0000_1060, "single0");
    check_val("b2b idle", bus.l2_request, 1'b0);
    step();
    check_val("b2b issue", bus.l2_request, 1'b1);
    serve(0, 32'h0000_1080, "single1");
    expect_quiet(0, 20, "single quiet");

    // Page crossing and 32-bit wrap-around.
    miss(0, 32'h0000_1FE0);
`ifdef L1I_PF_PAGE_CROSS_EN
    serve(0, 32'h0000_2000, "page0");
    serve(0, 32'h0000_2020, "page1");
    expect_quiet(0, 20, "page quiet");
`else
    expect_quiet(0, 20, "page dropped");
`endif
    miss(0, 32'hFFFF_FFE0);
`ifdef L1I_PF_PAGE_CROSS_EN
    serve(0, 32'h0000_0000, "wrap0");
    serve(0, 32'h0000_0020, "wrap1");
    expect_quiet(0, 20, "wrap quiet");
`else
    expect_quiet(0, 20, "wrap dropped");
`endif

    // Consecutive misses: each restarts the generator, only the last one's lines are requested.
    bus.miss_valid = 1'b1;
    bus.miss_paddr = 32'h100; step();
    bus.miss_paddr = 32'h120; step();
    bus.miss_paddr = 32'h140; step();
    bus.miss_valid = 1'b0;
    serve(0, 32'h160, "consec0");
    serve(0, 32'h180, "consec1");
    expect_quiet(0, 20, "consec quiet");

    // Blocking by demand_pending plus duplicate filtering against queued entries.
    bus.demand_pending = 1'b1;
    miss(0, 32'h100);
    step(); step(); step();
    miss(0, 32'h120);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.l2_request) seen = 1'b1;
    end
    check_val("blocked", seen, 1'b0);
    bus.demand_pending = 1'b0;
    step();
    check_val("unblock issue", {bus.l2_request, bus.l2_addr}, {1'b1, 32'h120});
    bus.demand_pending = 1'b1;
    step();
    step();
    check_val("dp in req", {bus.l2_request, bus.l2_addr}, {1'b1, 32'h120});
    bus.demand_pending = 1'b0;
    serve(0, 32'h120, "dup0");
    serve(0, 32'h140, "dup1");
    serve(0, 32'h160, "dup2");
    expect_quiet(0, 20, "dup quiet");

    // QDEPTH=2: fill, overflow drop, then push+pop on a full queue in the same cycle.
    bus2.demand_pending = 1'b1;
    miss(1, 32'h100);
    for (int i = 0; i < 6; i++) step();
    bus2.miss_valid = 1'b1;
    bus2.miss_paddr = 32'h200;
    step();
    bus2.miss_valid = 1'b0;
    bus2.demand_pending = 1'b0;
    step();
    check_val("full pushpop", {bus2.l2_request, bus2.l2_addr}, {1'b1, 32'h120});
    for (int i = 0; i < 6; i++) step();
    serve(1, 32'h120, "full0");
    serve(1, 32'h140, "full1");
    serve(1, 32'h220, "full2");
    expect_quiet(1, 20, "full quiet");

    // Reset while a request is outstanding; the late l2_done must be ignored.
    miss(0, 32'h400);
    for (int i = 0; i < 10 && !bus.l2_request; i++) step();
    check_val("rreq issue", {bus.l2_request, bus.l2_addr}, {1'b1, 32'h420});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rreq dropped", {bus.l2_request, bus.l2_addr}, {1'b0, 32'h0});
    check_val("rreq pa", bus.prefetch_addr, 32'h0);
    drive_done(0, 1'b1, pat(32'h420));
    step();
    drive_done(0, 1'b0, '0);
    check_val("rreq no pv", bus.prefetch_valid, 1'b0);
    expect_quiet(0, 20, "rreq quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/l1i_prefetcher.md
L1I_PREFETCHER -- requirements
Module: l1i_prefetcher

Interface
REQ-001 Parameter DEGREE, default 2, number of sequential lines queued per miss (1..4).
REQ-002 Parameter QDEPTH, default 4, depth of the candidate queue (power of two).
REQ-003 clk  input  1  single clock; every flop is updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 miss_valid  input  1  one-cycle pulse: L1I demand lookup missed.
REQ-006 miss_paddr  input  32  physical address of the missing fetch.
REQ-007 demand_pending  input  1  L1I demand fill in flight; new prefetch issue is blocked while high.
REQ-008 l2_addr  output  32  32B-aligned prefetch line address to L2.
REQ-009 l2_request  output  1  level request to L2, held until l2_done.
REQ-010 l2_data  input  256  returned line, valid when l2_done=1.
REQ-011 l2_done  input  1  one-cycle L2 completion pulse.
REQ-012 prefetch_addr  output  32  line address written into L1I.
REQ-013 prefetch_data  output  256  line data written into L1I.
REQ-014 prefetch_valid  output  1  one-cycle L1I write strobe.

Function
REQ-015 On miss_valid, candidates = line(miss_paddr)+k*32 for k=1..DEGREE are computed on a line basis (low 5 bits zero) with 32-bit wrap-around.
REQ-016 Candidates are pushed in ascending k, one per cycle, from a small generator; a new miss_valid during generation restarts generation from the new address.
REQ-017 A candidate equal to the last-issued line address or to any queued entry is dropped (duplicate filter).
REQ-018 Queue full: a new candidate is dropped, never overwriting existing entries; a push and a pop in the same cycle on a full queue both succeed.
REQ-019 The FSM has three states: IDLE, REQ, WRITE.
REQ-020 IDLE: if the queue is non-empty and demand_pending=0, pop the head, drive l2_addr=head, set l2_request=1 on the next edge, and move to REQ.
REQ-021 REQ: l2_request is held at 1 and l2_addr is held stable until l2_done; on l2_done, l2_request clears to 0, prefetch_addr/prefetch_data latch l2_addr/l2_data, prefetch_valid goes to 1, and the FSM moves to WRITE.
REQ-022 WRITE: prefetch_valid stays high for exactly one cycle, then the FSM returns to IDLE; the earliest back-to-back next issue is on the following edge.
REQ-023 l2_done while in IDLE or WRITE is ignored.
REQ-024 Latency: miss_valid at edge t -> first candidate queued at t+1 -> l2_request high after edge t+2 (queue empty, IDLE, demand_pending=0).
REQ-025 demand_pending rising while in REQ does not abort the outstanding request.

Reset
REQ-026 Reset clears the queue, the generator, and the last-issued register, and sets state=IDLE.
REQ-027 Reset values: l2_request=0, l2_addr=0, prefetch_valid=0, prefetch_addr=0, prefetch_data=0.
REQ-028 Reset mid-request drops l2_request on the next edge; any later l2_done for that request is ignored.

Configuration
REQ-029 Macro L1I_PF_PAGE_CROSS_EN defined: candidates crossing a 4KB page boundary (bits 31:12 differ from miss_paddr) are queued normally.
REQ-030 Macro L1I_PF_PAGE_CROSS_EN undefined: such candidates are dropped, and generation stops at the first cross-page candidate.

Structure
REQ-031 Package l1i_pkg holds: the FSM state enum; LINE_BYTES=32; PAGE_BITS=12; a line-address type of 27 bits.
REQ-032 The candidate queue is a sub-module pf_queue (push, pop, full, empty, match-lookup port); the FSM and generator stay in l1i_prefetcher.

Verification
REQ-033 Single miss: miss_paddr=0x0000_1040, DEGREE=2, demand_pending=0 -> L2 requests 0x0000_1060 then 0x0000_1080, each followed by one prefetch_valid pulse carrying the matching l2_data.
REQ-034 Page cross: miss_paddr=0x0000_1FE0 -> with macro, requests 0x0000_2000 and 0x0000_2020; without macro, no l2_request at all.
REQ-035 Duplicates and full queue: misses at 0x100, 0x120, 0x140 in consecutive cycles -> no address is requested twice; with QDEPTH=2 and L2 stalled, excess candidates are dropped and the queue holds exactly 2 entries.
REQ-036 Blocking: demand_pending=1 for 10 cycles with a non-empty queue -> l2_request stays 0; first l2_request appears on the edge after demand_pending falls.
REQ-037 Reset in REQ: assert reset one cycle, then pulse l2_done -> l2_request=0, prefetch_valid never pulses, queue empty.
REQ-038 Wrap-around: miss_paddr=0xFFFF_FFE0 with macro -> request 0x0000_0000 is issued; without macro, it is dropped.
